// File: rtl/cam_fb_writer_if.sv
// Bundle of camera-side inputs, frame-buffer write port and status for cam_fb_writer.
// Channel i lives at index [i] of every packed per-channel field.
interface cam_fb_writer_if #(
  parameter int N_CH   = 2,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 15
);
  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0]            sel;
  logic                        mode;
  logic                        xflip;
  logic [N_CH-1:0]             cam_valid;
  logic [N_CH-1:0][PIX_W-1:0]  cam_data;
  logic [N_CH-1:0][9:0]        cam_row;
  logic [N_CH-1:0][9:0]        cam_col;
  logic [N_CH-1:0]             cam_frame_done;
  logic                        fb_we;
  logic [ADDR_W-1:0]           fb_waddr;
  logic [PIX_W-1:0]            fb_wdata;
  logic [SEL_W-1:0]            active_sel;
  logic                        active_mode;
  logic [N_CH-1:0]             overflow;

  modport master (
    output sel, mode, xflip, cam_valid, cam_data, cam_row, cam_col, cam_frame_done,
    input  fb_we, fb_waddr, fb_wdata, active_sel, active_mode, overflow
  );

  modport slave (
    input  sel, mode, xflip, cam_valid, cam_data, cam_row, cam_col, cam_frame_done,
    output fb_we, fb_waddr, fb_wdata, active_sel, active_mode, overflow
  );
endinterface

// File: rtl/cam_fb_writer.sv
// N-channel camera to frame-buffer writer: per-channel decimation, address
// generation and FIFO, round-robin merge onto one write port, frame-aligned switching.

module cam_fb_chan #(
  parameter int N_CH       = 2,
  parameter int PIX_W      = 16,
  parameter int FB_STRIDE  = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CH         = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic              xflip_i,
  input  logic              valid_i,
  input  logic [PIX_W-1:0]  data_i,
  input  logic [9:0]        row_i,
  input  logic [9:0]        col_i,
  input  logic              frame_done_i,
  input  logic              pop_i,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [PIX_W-1:0]  head_data_o,
  output logic              overflow_o
);
  localparam int W_T   = FB_STRIDE / N_CH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              accept;
  logic [ADDR_W-1:0] addr;
  int                win_w, xi, yi, xe;

  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [PIX_W-1:0]  data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, push_ok, ovf_set;

  always_comb begin
    win_w  = mode_i ? W_T : FB_STRIDE;
    yi     = int'(row_i >> DECIM_LOG2);
    xi     = int'(col_i >> DECIM_LOG2);
    xe     = xflip_i ? (win_w - 1 - xi) : xi;
    accept = valid_i && en_i
          && (row_i[DECIM_LOG2-1:0] == '0) && (col_i[DECIM_LOG2-1:0] == '0)
          && (yi < FB_H) && (xi < win_w);
    // Tile offset uses the tile width; in single mode the window is the full row.
    addr   = ADDR_W'(yi * FB_STRIDE + xe + (mode_i ? CH * W_T : 0));
  end

  // A full FIFO still takes a push when it is being popped in the same cycle.
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_ok = accept && (!full || pop_i);
  assign ovf_set = accept && full && !pop_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_i);
    ovf_d    = ovf_q;
    if (ovf_set)           ovf_d = 1'b1;
    else if (frame_done_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= addr;
      data_mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign empty_o     = (cnt_q == '0);
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign overflow_o  = ovf_q;
endmodule

module cam_fb_writer #(
  parameter int N_CH       = 2,
  parameter int PIX_W      = 16,
  parameter int FB_STRIDE  = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  cam_fb_writer_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]             en, empty, pop, ovf;
  logic [N_CH-1:0][ADDR_W-1:0] head_addr;
  logic [N_CH-1:0][PIX_W-1:0]  head_data;

  logic [SEL_W-1:0]  active_sel_q, active_sel_d, rr_q, rr_d, ref_ch, gnt_idx;
  logic              active_mode_q, active_mode_d, gnt_vld;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_waddr_q, fb_waddr_d;
  logic [PIX_W-1:0]  fb_wdata_q, fb_wdata_d;
  int                c;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign en[i] = active_mode_q || (active_sel_q == SEL_W'(i));
    cam_fb_chan #(
      .N_CH(N_CH), .PIX_W(PIX_W), .FB_STRIDE(FB_STRIDE), .FB_H(FB_H),
      .ADDR_W(ADDR_W), .DECIM_LOG2(DECIM_LOG2), .FIFO_DEPTH(FIFO_DEPTH), .CH(i)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en_i         (en[i]),
      .mode_i       (active_mode_q),
      .xflip_i      (bus.xflip),
      .valid_i      (bus.cam_valid[i]),
      .data_i       (bus.cam_data[i]),
      .row_i        (bus.cam_row[i]),
      .col_i        (bus.cam_col[i]),
      .frame_done_i (bus.cam_frame_done[i]),
      .pop_i        (pop[i]),
      .empty_o      (empty[i]),
      .head_addr_o  (head_addr[i]),
      .head_data_o  (head_data[i]),
      .overflow_o   (ovf[i])
    );
  end

  // Round-robin: scan starting one past the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    c       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(rr_q) + k) % N_CH;
      if (!gnt_vld && !empty[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(c);
      end
    end
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    fb_we_d    = gnt_vld;
    fb_waddr_d = fb_waddr_q;
    fb_wdata_d = fb_wdata_q;
    rr_d       = rr_q;
    if (gnt_vld) begin
      fb_waddr_d = head_addr[gnt_idx];
      fb_wdata_d = head_data[gnt_idx];
      rr_d       = gnt_idx;
    end
  end

  // Requested sel/mode are only adopted at the reference channel's frame end,
  // so the latest request before that boundary is the one that sticks.
  always_comb begin
    ref_ch        = active_mode_q ? '0 : active_sel_q;
    active_sel_d  = active_sel_q;
    active_mode_d = active_mode_q;
    if (bus.cam_frame_done[ref_ch]) begin
      active_sel_d  = bus.sel;
      active_mode_d = bus.mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we_q       <= 1'b0;
      fb_waddr_q    <= '0;
      fb_wdata_q    <= '0;
      rr_q          <= '0;
      active_sel_q  <= '0;
      active_mode_q <= 1'b0;
    end else begin
      fb_we_q       <= fb_we_d;
      fb_waddr_q    <= fb_waddr_d;
      fb_wdata_q    <= fb_wdata_d;
      rr_q          <= rr_d;
      active_sel_q  <= active_sel_d;
      active_mode_q <= active_mode_d;
    end
  end

  assign bus.fb_we       = fb_we_q;
  assign bus.fb_waddr    = fb_waddr_q;
  assign bus.fb_wdata    = fb_wdata_q;
  assign bus.active_sel  = active_sel_q;
  assign bus.active_mode = active_mode_q;
  assign bus.overflow    = ovf;
endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer: driver pushes expected writes per channel,
// a negedge monitor matches every fb_we against the channel queue heads.
module tb_cam_fb_writer;
  localparam int N_CH = 2, PIX_W = 16, FB_STRIDE = 160, FB_H = 120, ADDR_W = 15;
  localparam int DEC = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cam_fb_writer_if #(.N_CH(N_CH), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus();

  cam_fb_writer #(
    .N_CH(N_CH), .PIX_W(PIX_W), .FB_STRIDE(FB_STRIDE), .FB_H(FB_H),
    .ADDR_W(ADDR_W), .DECIM_LOG2(DEC), .FIFO_DEPTH(DEPTH)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [PIX_W-1:0]  d;
  } wr_t;

  wr_t expq [N_CH][$];
  int  wr_log [$];
  int  total = 0, bad = 0;
  int  n_wr = 0;
  int  m_sel = 0, m_mode = 0;
  bit  strict = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: decimate, window-check and address one pixel from the rules.
  function automatic bit model_pix(input int ch, input int row, input int col,
                                   input bit xf, output logic [ADDR_W-1:0] a);
    int w, x, y, xe;
    w = m_mode ? FB_STRIDE / N_CH : FB_STRIDE;
    a = '0;
    if (!(m_mode != 0 || m_sel == ch)) return 1'b0;
    if (row % (1 << DEC) != 0 || col % (1 << DEC) != 0) return 1'b0;
    y = row / (1 << DEC);
    x = col / (1 << DEC);
    if (y >= FB_H || x >= w) return 1'b0;
    xe = xf ? (w - 1 - x) : x;
    a = ADDR_W'((y * FB_STRIDE + xe + (m_mode != 0 ? ch * w : 0)) % (1 << ADDR_W));
    return 1'b1;
  endfunction

  task automatic step();
    logic [ADDR_W-1:0] a;
    int rf;
    @(posedge clk);
    for (int ch = 0; ch < N_CH; ch++)
      if (bus.cam_valid[ch] &&
          model_pix(ch, int'(bus.cam_row[ch]), int'(bus.cam_col[ch]), bus.xflip, a))
        expq[ch].push_back({a, bus.cam_data[ch]});
    rf = m_mode != 0 ? 0 : m_sel;
    if (bus.cam_frame_done[rf]) begin
      m_sel  = int'(bus.sel);
      m_mode = int'(bus.mode);
    end
    #1;
    bus.cam_valid      = '0;
    bus.cam_frame_done = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pix(input int ch, input int row, input int col, input logic [PIX_W-1:0] d);
    bus.cam_valid[ch] = 1'b1;
    bus.cam_row[ch]   = 10'(row);
    bus.cam_col[ch]   = 10'(col);
    bus.cam_data[ch]  = d;
  endtask

  task automatic switch_to(input int s, input int m);
    bus.sel  = 1'(s);
    bus.mode = 1'(m);
    bus.cam_frame_done[m_mode != 0 ? 0 : m_sel] = 1'b1;
    step();
  endtask

  task automatic clear_sb();
    for (int ch = 0; ch < N_CH; ch++) expq[ch].delete();
  endtask

  // Monitor: every write must match a queued expectation (head only when strict).
  always @(negedge clk) begin : mon
    wr_t w;
    int  hit, pos;
    if (!reset) begin
      if (bus.fb_we) begin
        w = {bus.fb_waddr, bus.fb_wdata};
        hit = -1; pos = 0;
        n_wr++;
        for (int ch = 0; ch < N_CH && hit < 0; ch++) begin
          if (strict) begin
            if (expq[ch].size() > 0 && expq[ch][0] == w) hit = ch;
          end else begin
            for (int j = 0; j < expq[ch].size() && hit < 0; j++)
              if (expq[ch][j] == w) begin hit = ch; pos = j; end
          end
        end
        total++;
        if (hit < 0) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0h want a queued pixel", bus.fb_waddr, bus.fb_wdata);
        end else begin
          repeat (pos + 1) void'(expq[hit].pop_front());
          wr_log.push_back(hit);
        end
      end
      check("active_sel", 32'(bus.active_sel), 32'(m_sel));
      check("active_mode", 32'(bus.active_mode), 32'(m_mode));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n0, n1, cnt, ovf_seen, we_cnt;
    reset = 1'b1;
    bus.sel = '0; bus.mode = 1'b0; bus.xflip = 1'b0;
    bus.cam_valid = '0; bus.cam_data = '0; bus.cam_row = '0; bus.cam_col = '0;
    bus.cam_frame_done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.fb_we), 0);
    check("rst_waddr", 32'(bus.fb_waddr), 0);
    check("rst_wdata", 32'(bus.fb_wdata), 0);
    check("rst_sel", 32'(bus.active_sel), 0);
    check("rst_mode", 32'(bus.active_mode), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    reset = 1'b0;
    idle(2);

    // Single mode ch0: latency and address.
    pix(0, 8, 12, 16'hABCD);
    step();
    check("lat_t1_we", 32'(bus.fb_we), 0);
    step();
    check("lat_t2_we", 32'(bus.fb_we), 1);
    check("t1_addr", 32'(bus.fb_waddr), 323);
    check("t1_data", 32'(bus.fb_wdata), 32'hABCD);
    idle(2);
    s = n_wr;
    pix(0, 8, 13, 16'h1111); step();
    pix(0, 480, 12, 16'h2222); step();
    idle(4);
    check("drop_col_row", 32'(n_wr), 32'(s));

    // Tile mode addressing, with and without X flip.
    switch_to(0, 1);
    idle(1);
    pix(1, 4, 0, 16'h0101); step(); step();
    check("tile_addr", 32'(bus.fb_waddr), 240);
    bus.xflip = 1'b1;
    pix(1, 4, 0, 16'h0202); step(); step();
    check("tile_flip", 32'(bus.fb_waddr), 319);
    bus.xflip = 1'b0;
    idle(3);

    // Simultaneous pairs: first grant goes to the channel after the last one served.
    for (int lone = 0; lone < N_CH; lone++) begin
      pix(lone, 8, 0, 16'(32'h300 + lone)); step();
      idle(3);
      s = wr_log.size();
      pix(0, 12, 8, 16'(32'h400 + lone)); pix(1, 12, 8, 16'(32'h500 + lone)); step();
      step();
      check("pair_we1", 32'(bus.fb_we), 1);
      step();
      check("pair_we2", 32'(bus.fb_we), 1);
      idle(2);
      check("pair_cnt", 32'(wr_log.size() - s), 2);
      if (wr_log.size() >= s + 2) begin
        check("pair_first", 32'(wr_log[s]), 32'((lone + 1) % N_CH));
        check("pair_second", 32'(wr_log[s + 1]), 32'(lone));
      end
    end

    // Deferred switch: request ch1 mid-frame, only takes effect at ch0 frame end.
    switch_to(0, 0);
    idle(2);
    bus.sel = 1'b1;
    s = n_wr;
    for (int k = 0; k < 5; k++) begin pix(1, 0, 4 * k, 16'(32'h600 + k)); step(); end
    idle(3);
    check("defer_ignored", 32'(n_wr), 32'(s));
    check("defer_sel", 32'(bus.active_sel), 0);
    bus.cam_frame_done[0] = 1'b1;
    pix(1, 0, 8, 16'h0777);
    step();
    pix(1, 0, 4, 16'h1234); step(); step();
    check("defer_we", 32'(bus.fb_we), 1);
    check("defer_addr", 32'(bus.fb_waddr), 1);
    idle(3);

    // Randomized traffic, at most one pixel per cycle so no FIFO can overflow.
    for (int it = 0; it < 800; it++) begin
      int ch, row, col;
      if ($urandom % 32 == 0) bus.sel = 1'($urandom % N_CH);
      if ($urandom % 32 == 0) bus.mode = 1'($urandom % 2);
      if ($urandom % 16 == 0) bus.xflip = ~bus.xflip;
      if ($urandom % 24 == 0) bus.cam_frame_done[$urandom % N_CH] = 1'b1;
      if ($urandom % 2 == 0) begin
        ch = int'($urandom % N_CH);
        if ($urandom % 2 == 0) begin
          row = 4 * int'($urandom_range(0, FB_H));
          col = 4 * int'($urandom_range(0, FB_STRIDE));
        end else begin
          row = int'($urandom % 1024);
          col = int'($urandom % 1024);
        end
        pix(ch, row, col, 16'($urandom));
      end
      step();
    end
    idle(10);
    check("rand_ovf", 32'(bus.overflow), 0);
    check("rand_drain", 32'(expq[0].size() + expq[1].size()), 0);

    // Overflow: tile mode, both channels every cycle.
    bus.xflip = 1'b0;
    strict = 1'b0;
    switch_to(0, 1);
    idle(3);
    ovf_seen = 0; we_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      pix(0, 8, 4 * k, 16'($urandom)); pix(1, 8, 4 * k, 16'($urandom));
      step();
      if (bus.overflow != '0 && ovf_seen == 0) ovf_seen = k + 1;
      if (k >= 2 && bus.fb_we) we_cnt++;
    end
    check("ovf_set", 32'(ovf_seen != 0 && ovf_seen <= 16), 1);
    check("ovf_rate", 32'(we_cnt), 14);
    bus.cam_frame_done = '1;
    step();
    check("ovf_clr", 32'(bus.overflow), 0);
    idle(12);
    check("ovf_drained", 32'(bus.fb_we), 0);

    // Switch while full: queued ch0 entries still drain after ch1 takes over.
    bus.sel = 1'b1; bus.mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pix(0, 16, 4 * k, 16'($urandom)); pix(1, 16, 4 * k, 16'($urandom));
      step();
    end
    bus.cam_frame_done[0] = 1'b1;
    pix(1, 20, 0, 16'($urandom));
    step();
    s = wr_log.size();
    for (int k = 1; k < 7; k++) begin pix(1, 20, 4 * k, 16'($urandom)); step(); end
    idle(16);
    n0 = 0; n1 = 0;
    for (int j = s; j < wr_log.size(); j++) if (wr_log[j] == 0) n0++; else n1++;
    check("sw_ch0_drain", 32'(n0), 4);
    check("sw_ch1_wr", 32'(n1 > 0), 1);
    clear_sb();
    strict = 1'b1;

    // Reset mid-stream with full FIFOs and overflow pending.
    strict = 1'b0;
    switch_to(1, 1);
    idle(2);
    for (int k = 0; k < 12; k++) begin
      pix(0, 24, 4 * k, 16'($urandom)); pix(1, 24, 4 * k, 16'($urandom));
      step();
    end
    check("pre_rst_ovf", 32'(bus.overflow != '0), 1);
    pix(0, 24, 60, 16'h0F0F); pix(1, 24, 60, 16'hF0F0);
    #2 reset = 1'b1;
    #1;
    check("arst_we", 32'(bus.fb_we), 0);
    check("arst_ovf", 32'(bus.overflow), 0);
    check("arst_sel", 32'(bus.active_sel), 0);
    check("arst_mode", 32'(bus.active_mode), 0);
    clear_sb();
    m_sel = 0; m_mode = 0;
    bus.cam_valid = '0; bus.sel = '0; bus.mode = 1'b0;
    strict = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    s = n_wr;
    idle(10);
    check("no_stale", 32'(n_wr), 32'(s));
    pix(0, 0, 0, 16'h5A5A); step(); step();
    check("post_rst_we", 32'(bus.fb_we), 1);
    check("post_rst_addr", 32'(bus.fb_waddr), 0);
    idle(3);
    check("final_drain", 32'(expq[0].size() + expq[1].size()), 0);

    cnt = total;
    $display("test done: total=%0d bad=%0d", cnt, bad);
    $finish;
  end
endmodule
